// File: rtl/mux_4x1_pkg.sv
// Shared constants and select-code enum for the registered 4-to-1 word selector.
package mux_4x1_pkg;

    localparam int MUX_4X1_WIDTH = 32;

    typedef enum logic [1:0] {
        SEL_IN1 = 2'd0,
        SEL_IN2 = 2'd1,
        SEL_IN3 = 2'd2,
        SEL_IN4 = 2'd3
    } sel_e;

endpackage

// File: rtl/mux_4x1_sel.sv
// Combinational 4-to-1 word select; the 2-bit code is fully decoded through sel_e.
module mux_4x1_sel
    import mux_4x1_pkg::*;
#(
    parameter int WIDTH = MUX_4X1_WIDTH
) (
    input  logic [WIDTH-1:0] i_in1,
    input  logic [WIDTH-1:0] i_in2,
    input  logic [WIDTH-1:0] i_in3,
    input  logic [WIDTH-1:0] i_in4,
    input  logic [1:0]       i_sel,
    output logic [WIDTH-1:0] o_data
);

    sel_e w_sel;

    assign w_sel = sel_e'(i_sel);

    always_comb begin
        o_data = i_in1;
        unique case (w_sel)
            SEL_IN1: o_data = i_in1;
            SEL_IN2: o_data = i_in2;
            SEL_IN3: o_data = i_in3;
            SEL_IN4: o_data = i_in4;
        endcase
    end

endmodule

// File: rtl/mux_4x1.sv
// Registered 4-to-1 selector with valid qualifier, one cycle latency.
// Optional simulation-only checks are enabled by defining MUX_4X1_SEL_CHECK_EN.
module mux_4x1
    import mux_4x1_pkg::*;
#(
    parameter int WIDTH = MUX_4X1_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [WIDTH-1:0] in4,
    input  logic [1:0]       sel,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    logic [WIDTH-1:0] w_sel_data;
    logic [WIDTH-1:0] r_out;
    logic             r_valid;

    mux_4x1_sel #(
        .WIDTH (WIDTH)
    ) u_sel (
        .i_in1  (in1),
        .i_in2  (in2),
        .i_in3  (in3),
        .i_in4  (in4),
        .i_sel  (sel),
        .o_data (w_sel_data)
    );

    // Data holds when not qualified; the valid flag tracks in_valid every edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_out <= w_sel_data;
            end
        end
    end

    assign out       = r_out;
    assign out_valid = r_valid;

`ifdef MUX_4X1_SEL_CHECK_EN
    logic             r_chk_pend;
    logic [WIDTH-1:0] r_chk_exp;

    // Remember the word chosen at a qualified edge and confirm it landed on out.
    always_ff @(posedge clk) begin
        if (r_chk_pend === 1'b1 && out !== r_chk_exp) begin
            $error("mux_4x1: out %h differs from selected word %h", out, r_chk_exp);
        end
        if (rst_n && in_valid && $isunknown(sel)) begin
            $error("mux_4x1: sel is X/Z on a valid edge");
        end
        r_chk_pend <= rst_n && in_valid;
        r_chk_exp  <= w_sel_data;
    end
`endif

endmodule

// File: tb/tb_mux_4x1.sv
// Self-checking bench for mux_4x1: directed cases with literal expectations plus random traffic vs a model.
module tb_mux_4x1;

    logic        clk;
    logic        rst_n;
    logic [31:0] in1, in2, in3, in4;
    logic [1:0]  sel;
    logic        in_valid;
    logic [31:0] dut_out;
    logic        dut_out_valid;

    int n_vec  = 0;
    int n_miss = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_out   = '0;
    logic        m_valid = 1'b0;

    mux_4x1 #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .in4       (in4),
        .sel       (sel),
        .in_valid  (in_valid),
        .out       (dut_out),
        .out_valid (dut_out_valid)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Reference: words indexed by the select code, reset clears, invalid edges hold data.
    always @(posedge clk) begin
        logic [31:0] words [4];
        words[0] = in1;
        words[1] = in2;
        words[2] = in3;
        words[3] = in4;
        if (rst_n !== 1'b1) begin
            m_out   = '0;
            m_valid = 1'b0;
        end else begin
            m_valid = in_valid;
            if (in_valid) m_out = words[sel];
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_vec++;
            if (dut_out !== m_out || dut_out_valid !== m_valid) begin
                n_miss++;
                $display("FAIL model t=%0t out=%h valid=%b expected out=%h valid=%b",
                         $time, dut_out, dut_out_valid, m_out, m_valid);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic lit(input string name, input logic [31:0] exp_out, input logic exp_valid);
        n_vec++;
        if (dut_out !== exp_out || dut_out_valid !== exp_valid) begin
            n_miss++;
            $display("FAIL %s out=%h valid=%b expected out=%h valid=%b",
                     name, dut_out, dut_out_valid, exp_out, exp_valid);
        end else begin
            $display("ok   %s out=%h valid=%b", name, dut_out, dut_out_valid);
        end
    endtask

    initial begin
        logic [31:0] sweep [4];
        sweep[0] = 32'd54;
        sweep[1] = 32'd67;
        sweep[2] = 32'd89;
        sweep[3] = 32'd68;

        rst_n = 1'b0; in_valid = 1'b1; sel = 2'd0;
        in1 = 32'd54; in2 = '0; in3 = '0; in4 = '0;

        tick();
        chk_en = 1'b1;
        lit("reset_edge1", 32'd0, 1'b0);
        tick();
        lit("reset_edge2", 32'd0, 1'b0);
        rst_n = 1'b1;
        tick();
        lit("reset_release", 32'd54, 1'b1);

        in2 = 32'd67; in3 = 32'd89; in4 = 32'd68;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            tick();
            lit($sformatf("sweep_sel%0d", s), sweep[s], 1'b1);
        end
        sel = sel + 2'd1;
        tick();
        lit("wrap_to_0", 32'd54, 1'b1);

        sel = 2'd2;
        tick();
        lit("hold_pre", 32'd89, 1'b1);
        in_valid = 1'b0; sel = 2'd1; in3 = 32'd1234;
        tick();
        lit("hold_1", 32'd89, 1'b0);
        sel = 2'd2;
        tick();
        lit("hold_2", 32'd89, 1'b0);

        in_valid = 1'b1; in1 = '0; in2 = '0; in3 = '0; in4 = 32'hFFFF_FFFF; sel = 2'd3;
        tick();
        lit("width_ones", 32'hFFFF_FFFF, 1'b1);
        sel = 2'd0;
        tick();
        lit("width_zero", 32'd0, 1'b1);

        in3 = 32'd1234; sel = 2'd2;
        tick();
        lit("mid_pre", 32'd1234, 1'b1);
        rst_n = 1'b0; in3 = 32'd777;
        tick();
        lit("mid_reset", 32'd0, 1'b0);
        rst_n = 1'b1; in3 = 32'd4321;
        tick();
        lit("mid_resume", 32'd4321, 1'b1);

        for (int i = 0; i < 400; i++) begin
            in1      = $urandom;
            in2      = $urandom;
            in3      = $urandom;
            in4      = $urandom;
            sel      = 2'($urandom_range(0, 3));
            in_valid = ($urandom_range(0, 3) != 0);
            rst_n    = ($urandom_range(0, 24) != 0);
            tick();
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
